// File: rtl/q2_sequencer.sv
// Control sequencer for a bit-serial CPU: fetches an instruction, optionally dereferences,
// then runs a WIDTH-cycle serial ALU pass or a single store/jump step.
module q2_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic       mem_rdy,
  input  logic [2:0] opcode,
  input  logic       deref,
  input  logic       f,
  input  logic       x0,
  input  logic       alu_cout,
  input  logic       dbus_msb,
  input  logic       dep_sw,
  input  logic       incp_db,
  output logic [2:0] state,
  output logic       busy,
  output logic       rdp,
  output logic       rdx,
  output logic       rda,
  output logic       rdm,
  output logic       wro,
  output logic       wra,
  output logic       wrx,
  output logic       wrp,
  output logic       wrm,
  output logic       wrf,
  output logic       incp,
  output logic       fout,
  output logic [1:0] xhin_sel,
  output logic       xlin_sel
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_DEREF  = 3'd3,
    S_LOAD   = 3'd4,
    S_ALU    = 3'd5,
    S_EXEC   = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             exit_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  // Memory handshake: a memory state issues its read/write enable every cycle and
  // waits; the cycle with mem_rdy=1 is the completing cycle, and only that cycle
  // carries the capturing write strobe and advances the state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    exit_instr = 1'b0;
    rdp        = 1'b0;
    rda        = 1'b0;
    rdm        = 1'b0;
    wro        = 1'b0;
    wra        = 1'b0;
    wrx        = 1'b0;
    wrp        = 1'b0;
    wrm        = 1'b0;
    wrf        = 1'b0;
    incp       = 1'b0;
    fout       = 1'b0;
    xhin_sel   = 2'd0;
    xlin_sel   = 1'b0;

    case (state_q)
      S_IDLE: begin
        wrm  = dep_sw;
        incp = incp_db;
        if (run) begin
          state_d = S_FETCH;
        end else if (step) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
        end
      end

      S_FETCH: begin
        rdp      = 1'b1;
        xhin_sel = dbus_msb ? 2'd2 : 2'd1;
        if (mem_rdy) begin
          wro     = 1'b1;
          wrx     = 1'b1;
          incp    = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (deref)          state_d = S_DEREF;
        else if (!opcode[2]) state_d = S_LOAD;
        else                state_d = S_EXEC;
      end

      S_DEREF: begin
        rdm      = 1'b1;
        xhin_sel = 2'd3;
        if (mem_rdy) begin
          wrx     = 1'b1;
          state_d = opcode[2] ? S_EXEC : S_LOAD;
        end
      end

      S_LOAD: begin
        rdm      = 1'b1;
        xhin_sel = 2'd3;
        if (mem_rdy) begin
          wrx     = 1'b1;
          cnt_d   = '0;
          state_d = S_ALU;
        end
      end

      S_ALU: begin
        xlin_sel = 1'b1;
        wra      = 1'b1;
        wrx      = 1'b1;
        if (cnt_q == CntLast) begin
          // Flag is captured only once, from the final serial bit.
          wrf        = 1'b1;
          cnt_d      = '0;
          exit_instr = 1'b1;
          case (opcode)
            3'd0, 3'd1: fout = 1'b1;
            3'd2:       fout = alu_cout;
            3'd3:       fout = x0 | alu_cout;
            default:    fout = 1'b0;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_EXEC: begin
        rda = 1'b1;
        case (opcode)
          3'd5: begin
            if (mem_rdy) begin
              wrm        = 1'b1;
              exit_instr = 1'b1;
            end
          end
          3'd6: begin
            wrp        = 1'b1;
            exit_instr = 1'b1;
          end
          3'd7: begin
            wrp        = ~f;
            exit_instr = 1'b1;
          end
          default: exit_instr = 1'b1;
        endcase
      end

      default: state_d = S_IDLE;
    endcase

    // A pending single-step always returns to IDLE, even if run rose meanwhile.
    if (exit_instr) begin
      if (run && !step_q) begin
        state_d = S_FETCH;
      end else begin
        state_d = S_IDLE;
        step_d  = 1'b0;
      end
    end
  end

  assign state = state_q;
  assign busy  = (state_q != S_IDLE);
  assign rdx   = (state_q != S_IDLE) && (state_q != S_FETCH);

endmodule

// File: tb/tb_q2_sequencer.sv
// Bench for q2_sequencer: a generator turns instruction-level plans into per-cycle
// stimulus and expected outputs, which are compared cycle by cycle.
module tb_q2_sequencer;
  localparam int W  = 8;
  localparam int OW = 19;

  typedef struct packed {
    logic [2:0] st;
    logic busy, rdp, rdx, rda, rdm, wro, wra, wrx, wrp, wrm, wrf, incp, fout;
    logic [1:0] xh;
    logic xl;
  } obs_t;

  typedef struct packed {
    logic run, step, rdy;
    logic [2:0] op;
    logic dr, f, x0, ac, msb, dep, ip;
  } stim_t;

  logic clk, rst_n, run, step, mem_rdy, deref, f, x0, alu_cout, dbus_msb, dep_sw, incp_db;
  logic [2:0] opcode, state;
  logic busy, rdp, rdx, rda, rdm, wro, wra, wrx, wrp, wrm, wrf, incp, fout, xlin_sel;
  logic [1:0] xhin_sel;
  obs_t obs;

  logic [OW-1:0] exp_q[$];
  stim_t stim_q[$];
  int n_cmp, n_err;
  int c_wra, c_wrf, c_fout, c_wrm, c_wrp, c_wro, c_deref, c_exec;

  int g_f = -1, g_ac = -1, g_panel = -1;
  logic [2:0] g_op;
  logic g_dr;
  bit g_step;
  int g_idx, g_drop;

  q2_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .mem_rdy(mem_rdy),
    .opcode(opcode), .deref(deref), .f(f), .x0(x0), .alu_cout(alu_cout),
    .dbus_msb(dbus_msb), .dep_sw(dep_sw), .incp_db(incp_db),
    .state(state), .busy(busy), .rdp(rdp), .rdx(rdx), .rda(rda), .rdm(rdm),
    .wro(wro), .wra(wra), .wrx(wrx), .wrp(wrp), .wrm(wrm), .wrf(wrf),
    .incp(incp), .fout(fout), .xhin_sel(xhin_sel), .xlin_sel(xlin_sel)
  );

  assign obs = {state, busy, rdp, rdx, rda, rdm, wro, wra, wrx, wrp, wrm, wrf,
                incp, fout, xhin_sel, xlin_sel};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic pick(input int v);
    if (v < 0) return logic'($urandom_range(0, 1));
    return logic'(v[0]);
  endfunction

  task automatic gen_idle(input logic run_v, input logic step_v);
    stim_t s;
    obs_t e;
    s = '0;
    s.run = run_v; s.step = step_v; s.rdy = pick(-1); s.op = 3'($urandom_range(0, 7));
    s.dr = pick(-1); s.f = pick(-1); s.x0 = pick(-1); s.ac = pick(-1); s.msb = pick(-1);
    s.dep = pick(-1); s.ip = pick(-1);
    e = '0;
    e.wrm = s.dep;
    e.incp = s.ip;
    exp_q.push_back(e);
    stim_q.push_back(s);
  endtask

  task automatic gen_cycle(input logic [2:0] st, input logic rdy, input bit last, output logic run_v);
    stim_t s;
    obs_t e;
    s = '0;
    s.run = g_step ? logic'($urandom_range(0, 1)) : logic'(g_idx < g_drop);
    s.rdy = rdy; s.op = g_op; s.dr = g_dr;
    s.f = pick(g_f); s.x0 = pick(-1); s.ac = pick(g_ac); s.msb = pick(-1);
    s.dep = pick(g_panel); s.ip = pick(g_panel);
    e = '0;
    e.st = st;
    e.busy = 1'b1;
    e.rdx = (st != 3'd1);
    case (st)
      3'd1: begin
        e.rdp = 1'b1;
        e.xh = s.msb ? 2'd2 : 2'd1;
        if (rdy) begin e.wro = 1'b1; e.wrx = 1'b1; e.incp = 1'b1; end
      end
      3'd3, 3'd4: begin e.rdm = 1'b1; e.xh = 2'd3; e.wrx = rdy; end
      3'd5: begin
        e.xl = 1'b1; e.wra = 1'b1; e.wrx = 1'b1;
        if (last) begin
          e.wrf = 1'b1;
          if (g_op == 3'd2)      e.fout = s.ac;
          else if (g_op == 3'd3) e.fout = s.x0 | s.ac;
          else                   e.fout = 1'b1;
        end
      end
      3'd6: begin
        e.rda = 1'b1;
        if (g_op == 3'd5)      e.wrm = rdy;
        else if (g_op == 3'd6) e.wrp = 1'b1;
        else if (g_op == 3'd7) e.wrp = ~s.f;
      end
      default: ;
    endcase
    exp_q.push_back(e);
    stim_q.push_back(s);
    run_v = s.run;
    g_idx++;
  endtask

  task automatic gen_mem(input logic [2:0] st, input int wmin, input int wmax, output logic r);
    int w;
    w = $urandom_range(wmin, wmax);
    repeat (w) gen_cycle(st, 1'b0, 1'b0, r);
    gen_cycle(st, 1'b1, 1'b0, r);
  endtask

  // One instruction; drop = cycle index from which run is low (non-step mode).
  task automatic gen_instr(input bit sm, input logic [2:0] op, input logic dr,
                           input int wmin, input int wmax, input int drop, output bit to_idle);
    logic r;
    g_step = sm; g_op = op; g_dr = dr; g_idx = 0; g_drop = drop;
    gen_mem(3'd1, wmin, wmax, r);
    gen_cycle(3'd2, pick(-1), 1'b0, r);
    if (dr) gen_mem(3'd3, wmin, wmax, r);
    if (!op[2]) begin
      gen_mem(3'd4, wmin, wmax, r);
      for (int i = 0; i < W; i++) gen_cycle(3'd5, pick(-1), (i == W - 1), r);
    end else if (op == 3'd5) begin
      gen_mem(3'd6, wmin, wmax, r);
    end else begin
      gen_cycle(3'd6, pick(-1), 1'b0, r);
    end
    to_idle = sm || !r;
  endtask

  task automatic gen_prog(input int n, input int wmax);
    bit idle, sm;
    int drop;
    idle = 1'b1;
    for (int k = 0; k < n; k++) begin
      sm = 1'b0;
      if (idle) begin
        sm = ($urandom_range(0, 2) == 0);
        repeat ($urandom_range(0, 2)) gen_idle(1'b0, 1'b0);
        if (sm) gen_idle(1'b0, 1'b1);
        else    gen_idle(1'b1, logic'($urandom_range(0, 1)));
      end
      if (k == n - 1)                   drop = $urandom_range(0, 2);
      else if ($urandom_range(0, 3) == 0) drop = $urandom_range(0, 2 * W);
      else                              drop = 1000;
      gen_instr(sm, 3'($urandom_range(0, 7)), pick(-1), 0, wmax, drop, idle);
    end
    gen_idle(1'b0, 1'b0);
  endtask

  // ---------------- driver / scoreboard ----------------
  task automatic apply(input stim_t s);
    run = s.run; step = s.step; mem_rdy = s.rdy; opcode = s.op; deref = s.dr;
    f = s.f; x0 = s.x0; alu_cout = s.ac; dbus_msb = s.msb; dep_sw = s.dep; incp_db = s.ip;
  endtask

  task automatic clear_counts();
    c_wra = 0; c_wrf = 0; c_fout = 0; c_wrm = 0; c_wrp = 0; c_wro = 0; c_deref = 0; c_exec = 0;
  endtask

  task automatic run_queue(input string name, input int limit);
    obs_t want;
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < limit) begin
      apply(stim_q.pop_front());
      want = exp_q.pop_front();
      @(negedge clk);
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %b required %b", name, k, obs, want);
      end
      if (obs.wra) c_wra++;
      if (obs.wrf) c_wrf++;
      if (obs.fout) c_fout++;
      if (obs.wrm && obs.busy) c_wrm++;
      if (obs.wrp) c_wrp++;
      if (obs.wro) c_wro++;
      if (obs.st == 3'd3) c_deref++;
      if (obs.st == 3'd6) c_exec++;
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t zero;
    zero = '0;
    rst_n = 1'b0;
    apply('0);
    run = 1'b1; opcode = 3'd5; mem_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs !== zero) begin
      n_err++;
      $display("FAIL reset_hold: got %b required %b", obs, zero);
    end
    rst_n = 1'b1;
    run = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (obs !== zero) begin
      n_err++;
      $display("FAIL post_reset_idle: got %b required %b", obs, zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_panel();
    obs_t e;
    for (int i = 0; i < 4; i++) begin
      dep_sw = i[0];
      incp_db = i[1];
      e = '0;
      e.wrm = i[0];
      e.incp = i[1];
      @(negedge clk);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL idle_panel_%0d: got %b required %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
    dep_sw = 1'b0;
    incp_db = 1'b0;
  endtask

  task automatic test_alu_run();
    bit ti;
    g_ac = 1; g_panel = 1;
    gen_idle(1'b1, 1'b0);
    gen_instr(1'b0, 3'd2, 1'b0, 0, 0, 1000, ti);
    gen_instr(1'b0, 3'd4, 1'b0, 0, 0, 0, ti);
    gen_idle(1'b0, 1'b0);
    g_ac = -1; g_panel = -1;
    clear_counts();
    run_queue("alu_run", 1000);
    n_cmp++;
    if (c_wra !== W) begin n_err++; $display("FAIL alu_wra_count: got %0d required %0d", c_wra, W); end
    n_cmp++;
    if (c_wrf !== 1) begin n_err++; $display("FAIL alu_wrf_count: got %0d required 1", c_wrf); end
    n_cmp++;
    if (c_fout !== 1) begin n_err++; $display("FAIL alu_fout_count: got %0d required 1", c_fout); end
    n_cmp++;
    if (c_wrm !== 0) begin n_err++; $display("FAIL alu_panel_wrm: got %0d required 0", c_wrm); end
  endtask

  task automatic test_step_jump();
    bit ti;
    g_f = 1;
    gen_idle(1'b0, 1'b1);
    gen_instr(1'b1, 3'd7, 1'b0, 0, 0, 1000, ti);
    gen_idle(1'b0, 1'b0);
    clear_counts();
    run_queue("step_jump_f1", 1000);
    n_cmp++;
    if (c_wrp !== 0) begin n_err++; $display("FAIL step_wrp_f1: got %0d required 0", c_wrp); end
    g_f = 0;
    gen_idle(1'b0, 1'b1);
    gen_instr(1'b1, 3'd7, 1'b0, 0, 0, 1000, ti);
    gen_idle(1'b0, 1'b0);
    g_f = -1;
    clear_counts();
    run_queue("step_jump_f0", 1000);
    n_cmp++;
    if (c_wrp !== 1) begin n_err++; $display("FAIL step_wrp_f0: got %0d required 1", c_wrp); end
  endtask

  task automatic test_store_stall();
    bit ti;
    gen_idle(1'b1, 1'b0);
    gen_instr(1'b0, 3'd5, 1'b1, 3, 3, 0, ti);
    gen_idle(1'b0, 1'b0);
    clear_counts();
    run_queue("store_stall", 1000);
    n_cmp++;
    if (c_deref !== 4) begin n_err++; $display("FAIL deref_cycles: got %0d required 4", c_deref); end
    n_cmp++;
    if (c_exec !== 4) begin n_err++; $display("FAIL exec_cycles: got %0d required 4", c_exec); end
    n_cmp++;
    if (c_wrm !== 1) begin n_err++; $display("FAIL store_wrm_count: got %0d required 1", c_wrm); end
  endtask

  task automatic test_reset_mid_alu();
    bit ti;
    obs_t zero;
    zero = '0;
    gen_idle(1'b1, 1'b0);
    gen_instr(1'b0, 3'd2, 1'b0, 0, 0, 1000, ti);
    run_queue("pre_reset", 7);
    apply(stim_q.pop_front());
    dep_sw = 1'b0;
    incp_db = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== zero) begin n_err++; $display("FAIL async_reset_alu: got %b required %b", obs, zero); end
    exp_q.delete();
    stim_q.delete();
    run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs !== zero) begin n_err++; $display("FAIL reset_held_alu: got %b required %b", obs, zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    gen_idle(1'b1, 1'b0);
    gen_instr(1'b0, 3'd2, 1'b0, 0, 1, 0, ti);
    gen_idle(1'b0, 1'b0);
    clear_counts();
    run_queue("after_reset", 1000);
    n_cmp++;
    if (c_wra !== W) begin n_err++; $display("FAIL after_reset_wra: got %0d required %0d", c_wra, W); end
  endtask

  task automatic test_back_to_back();
    bit ti;
    gen_idle(1'b1, 1'b0);
    for (int k = 0; k < 6; k++)
      gen_instr(1'b0, 3'($urandom_range(0, 7)), pick(-1), 0, 1, (k == 5) ? 0 : 1000, ti);
    gen_idle(1'b0, 1'b0);
    clear_counts();
    run_queue("back_to_back", 1000);
    n_cmp++;
    if (c_wro !== 6) begin n_err++; $display("FAIL b2b_fetch_count: got %0d required 6", c_wro); end
  endtask

  task automatic test_random();
    gen_prog(40, 3);
    run_queue("random_prog", 100000);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_panel();
    test_alu_run();
    test_step_jump();
    test_store_stall();
    test_reset_mid_alu();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
